// File: rtl/mod_pow_pkg.sv
// Shared state encoding and latency helper for the modular exponentiator.
package mod_pow_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int unsigned CHECK_CYCLES = 2;

  // Cycles from the start-sampling edge to done, for k loop iterations.
  function automatic int unsigned pow_latency(input int unsigned nbits, input int unsigned k);
    return CHECK_CYCLES + k * (nbits + 1);
  endfunction

endpackage

// File: rtl/mod_mul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, MSB-first over a.
module mod_mul #(
  parameter int unsigned NBITS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] n,
  output logic             done,
  output logic [NBITS-1:0] p
);

  localparam int unsigned PW = NBITS + 2;
  localparam int unsigned CW = $clog2(NBITS + 1);

  logic [NBITS-1:0] r_a;
  logic [NBITS-1:0] r_b;
  logic [NBITS-1:0] r_n;
  logic [CW-1:0]    r_cnt;
  logic             r_run;

  logic             w_bit;
  logic [NBITS-1:0] w_b;
  logic [NBITS-1:0] w_n;
  logic [PW-1:0]    w_p_in;
  logic [PW-1:0]    w_t0;
  logic [PW-1:0]    w_t1;
  logic [NBITS-1:0] w_t2;

  // The first bit is consumed on the start edge itself so done lands NBITS cycles later.
  always_comb begin
    w_bit  = start ? a[NBITS-1] : r_a[NBITS-1];
    w_b    = start ? b : r_b;
    w_n    = start ? n : r_n;
    w_p_in = start ? '0 : PW'(p);
    w_t0   = (w_p_in << 1) + (w_bit ? PW'(w_b) : '0);
    w_t1   = (w_t0 >= PW'(w_n)) ? (w_t0 - PW'(w_n)) : w_t0;
    w_t2   = NBITS'((w_t1 >= PW'(w_n)) ? (w_t1 - PW'(w_n)) : w_t1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_n   <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        r_a   <= a << 1;
        r_b   <= b;
        r_n   <= n;
        p     <= w_t2;
        r_cnt <= CW'(NBITS - 1);
        r_run <= (NBITS != 1);
        done  <= (NBITS == 1);
      end else if (r_run) begin
        r_a   <= r_a << 1;
        p     <= w_t2;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_run <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mod_pow_param.sv
// Modular exponentiator: result = base^expo mod modulus, right-to-left square-and-multiply.
module mod_pow_param
  import mod_pow_pkg::*;
#(
  parameter int unsigned NBITS = 256,
  parameter int unsigned EBITS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] expo,
  input  logic [NBITS-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NBITS-1:0] result
);

  state_t           r_state;
  logic [NBITS-1:0] r_base;
  logic [NBITS-1:0] r_mod;
  logic [EBITS-1:0] r_e;
  logic [NBITS-1:0] r_r;
  logic [NBITS-1:0] r_b;

  logic             w_mul_start;
  logic             w_done0;
  logic             w_done1;
  logic [NBITS-1:0] w_p0;
  logic [NBITS-1:0] w_p1;
  logic [NBITS-1:0] w_r_next;
  logic [EBITS-1:0] w_e_next;

  assign w_mul_start = (r_state == S_ISSUE);
  assign w_r_next    = r_e[0] ? w_p0 : r_r;
  assign w_e_next    = r_e >> 1;

  // mul0 accumulates R*B, mul1 squares B, both in lock-step.
  mod_mul #(.NBITS(NBITS)) mul0 (
    .clk   (clk),
    .rst   (rst),
    .start (w_mul_start),
    .a     (r_r),
    .b     (r_b),
    .n     (r_mod),
    .done  (w_done0),
    .p     (w_p0)
  );

  mod_mul #(.NBITS(NBITS)) mul1 (
    .clk   (clk),
    .rst   (rst),
    .start (w_mul_start),
    .a     (r_b),
    .b     (r_b),
    .n     (r_mod),
    .done  (w_done1),
    .p     (w_p1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_mod   <= '0;
      r_e     <= '0;
      r_r     <= '0;
      r_b     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base  <= base;
            r_e     <= expo;
            r_mod   <= modulus;
            err     <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if ((r_mod == '0) || (r_base >= r_mod)) begin
            err     <= 1'b1;
            result  <= '0;
            r_state <= S_DONE;
          end else if (r_mod == NBITS'(1)) begin
            result  <= '0;
            r_state <= S_DONE;
          end else if (r_e == '0) begin
            result  <= NBITS'(1);
            r_state <= S_DONE;
          end else begin
            r_r     <= NBITS'(1);
            r_b     <= r_base;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (w_done0 && w_done1) begin
            r_b <= w_p1;
            r_r <= w_r_next;
            r_e <= w_e_next;
            if (w_e_next == '0) begin
              result  <= w_r_next;
              r_state <= S_DONE;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
